// File: rtl/spi_pkg.sv
// Shared encodings for the SPI arbiter: SPI modes, clock divider codes
// and the arbiter FSM state values.
package spi_pkg;

  // SPI mode encodings (CPOL/CPHA pairs as understood by spi_master)
  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  // spi_master clock divider codes
  localparam logic [1:0] DIV4  = 2'd0;
  localparam logic [1:0] DIV8  = 2'd1;
  localparam logic [1:0] DIV16 = 2'd2;
  localparam logic [1:0] DIV32 = 2'd3;

  // Arbiter FSM states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the position just
// above ptr and wraps, so the last winner has the lowest priority. The
// pointer register itself belongs to the parent.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            valid
);

  // Rotating priority search: first set request at (ptr+1), (ptr+2), ... mod NREQ
  always_comb begin
    logic           found_s;
    logic [IDW-1:0] pos_s;
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    pos_s     = '0;
    for (int off = 1; off <= NREQ; off++) begin
      pos_s = IDW'((int'(ptr) + off) % NREQ);
      if (en && !found_s && req[pos_s]) begin
        found_s        = 1'b1;
        grant[pos_s]   = 1'b1;
        grant_idx      = pos_s;
      end else begin
        found_s = found_s;
      end
    end
    valid = found_s;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between NREQ requesters. Round-robin grant, one byte
// per grant, per-requester mode/divider/slave select, and a timeout that
// resets a hung master and completes the transaction with err.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1023,
  parameter int TOW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_tx,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [2*NREQ-1:0] req_clkdiv,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [7:0]        rx_data,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              m_start,
  output logic [1:0]        m_mode,
  output logic [1:0]        m_clkdiv,
  output logic [7:0]        m_tx,
  output logic              m_rst,
  input  logic              m_finish,
  input  logic [7:0]        m_rx,
  input  logic              m_ss,
  output logic [NREQ-1:0]   ss_out
);

  localparam logic [TOW-1:0] TO_LIM = TOW'(TIMEOUT);

  logic [2:0]      state_r;
  logic [IDW-1:0]  rr_r;
  logic [IDW-1:0]  grant_id_r;
  logic [NREQ-1:0] grant_oh_r;
  logic [1:0]      mode_r;
  logic [1:0]      clkdiv_r;
  logic [7:0]      tx_r;
  logic [7:0]      rx_r;
  logic [NREQ-1:0] ack_r;
  logic            err_r;
  logic            abort_r;
  logic            start_r;
  logic [TOW-1:0]  cnt_r;

  logic [NREQ-1:0] arb_grant_s;
  logic [IDW-1:0]  arb_idx_s;
  logic            arb_valid_s;
  logic [1:0]      sel_mode_s;
  logic [1:0]      sel_div_s;
  logic [7:0]      sel_tx_s;
  logic [TOW-1:0]  cnt_inc_s;
  logic            to_hit_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req       (req),
    .ptr       (rr_r),
    .en        (state_r == ST_IDLE),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .valid     (arb_valid_s)
  );

  // Select the candidate winner's configuration for loading at grant
  always_comb begin
    sel_mode_s = 2'b00;
    sel_div_s  = 2'b00;
    sel_tx_s   = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx_s == IDW'(i)) begin
        sel_mode_s = req_mode[2*i +: 2];
        sel_div_s  = req_clkdiv[2*i +: 2];
        sel_tx_s   = req_tx[8*i +: 8];
      end else begin
        sel_mode_s = sel_mode_s;
      end
    end
  end

  // Timeout counter step; the limit is shared by WAIT_BUSY and WAIT_DONE
  always_comb begin
    cnt_inc_s = cnt_r + TOW'(1);
    to_hit_s  = (cnt_inc_s == TO_LIM);
  end

  // Arbitration FSM with registered master controls and responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rr_r       <= IDW'(NREQ - 1);
      grant_id_r <= '0;
      grant_oh_r <= '0;
      mode_r     <= 2'b00;
      clkdiv_r   <= 2'b00;
      tx_r       <= 8'h00;
      rx_r       <= 8'h00;
      ack_r      <= '0;
      err_r      <= 1'b0;
      abort_r    <= 1'b0;
      start_r    <= 1'b0;
      cnt_r      <= '0;
    end else begin
      // one-cycle pulses default low
      ack_r   <= '0;
      err_r   <= 1'b0;
      abort_r <= 1'b0;
      start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            grant_id_r <= arb_idx_s;
            grant_oh_r <= arb_grant_s;
            rr_r       <= arb_idx_s;
            mode_r     <= sel_mode_s;
            clkdiv_r   <= sel_div_s;
            tx_r       <= sel_tx_s;
            start_r    <= 1'b1;
            cnt_r      <= '0;
            state_r    <= ST_LAUNCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!m_finish) begin
            cnt_r   <= '0;
            state_r <= ST_WAIT_DONE;
          end else if (to_hit_s) begin
            // master never acknowledged the start: abort
            abort_r <= 1'b1;
            rx_r    <= 8'h00;
            err_r   <= 1'b1;
            ack_r   <= grant_oh_r;
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_WAIT_DONE: begin
          // completion wins over a coincident timeout
          if (m_finish) begin
            rx_r    <= m_rx;
            ack_r   <= grant_oh_r;
            state_r <= ST_RESP;
          end else if (to_hit_s) begin
            abort_r <= 1'b1;
            rx_r    <= 8'h00;
            err_r   <= 1'b1;
            ack_r   <= grant_oh_r;
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Route the master's single select to the granted slave only while busy
  always_comb begin
    ss_out = '1;
    for (int i = 0; i < NREQ; i++) begin
      if (busy && (grant_id_r == IDW'(i))) begin
        ss_out[i] = m_ss;
      end else begin
        ss_out[i] = 1'b1;
      end
    end
  end

  assign busy     = (state_r != ST_IDLE);
  assign ack      = ack_r;
  assign err      = err_r;
  assign rx_data  = rx_r;
  assign grant_id = grant_id_r;
  assign m_start  = start_r;
  assign m_mode   = mode_r;
  assign m_clkdiv = clkdiv_r;
  assign m_tx     = tx_r;
  assign m_rst    = rst | abort_r;

endmodule
